// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path: FSM states,
// opcode/func values, ALU operation codes and error codes.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_ADDIU = 6'd9;

  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SUBU = 6'h23;
  localparam logic [5:0] FUNC_AND  = 6'h24;
  localparam logic [5:0] FUNC_OR   = 6'h25;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/instr_sequencer_field_ctrl.sv
// Combinational opcode/func decode into ALU/register-file controls; zero latency,
// no flow control. Unsupported encodings report legal=0 with all controls at 0.
module instr_field_ctrl
  import instr_sequencer_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic       legal,
  output logic [1:0] alu_op,
  output logic       alu_src_imm,
  output logic       rf_dst_rd
);

  always_comb begin
    legal       = 1'b0;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    rf_dst_rd   = 1'b0;
    if (opcode == OPC_ADDIU) begin
      legal       = 1'b1;
      alu_src_imm = 1'b1;
    end else if (opcode == OPC_RTYPE) begin
      case (func)
        FUNC_ADDU: begin legal = 1'b1; rf_dst_rd = 1'b1; alu_op = ALU_ADD; end
        FUNC_SUBU: begin legal = 1'b1; rf_dst_rd = 1'b1; alu_op = ALU_SUB; end
        FUNC_AND:  begin legal = 1'b1; rf_dst_rd = 1'b1; alu_op = ALU_AND; end
        FUNC_OR:   begin legal = 1'b1; rf_dst_rd = 1'b1; alu_op = ALU_OR;  end
        default:   legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer: 4 cycles per instruction plus one per
// imem ack wait; a fetch with no ack for ACK_TMO cycles ends in ERROR.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int PROG_LEN = 16,
  parameter int ACK_TMO  = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [31:0]     instruct,
  output logic            decode_enable,
  input  logic [5:0]      opcode,
  input  logic [5:0]      func,
  output logic            rf_read_en,
  output logic            alu_en,
  output logic [1:0]      alu_op,
  output logic            alu_src_imm,
  output logic            rf_write_en,
  output logic            rf_dst_rd,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [PC_W-1:0] pc
);

  localparam int              TMO_W    = $clog2(ACK_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);
  localparam logic [PC_W-1:0]  LAST_PC  = PC_W'(PROG_LEN - 1);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic       fc_legal;
  logic [1:0] fc_alu_op;
  logic       fc_src_imm;
  logic       fc_dst_rd;

  instr_field_ctrl u_field_ctrl (
    .opcode      (opcode),
    .func        (func),
    .legal       (fc_legal),
    .alu_op      (fc_alu_op),
    .alu_src_imm (fc_src_imm),
    .rf_dst_rd   (fc_dst_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      err_code_q <= ERR_NONE;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      err_code_q <= err_code_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    err_code_d    = err_code_q;
    tmo_d         = tmo_q;
    imem_req      = 1'b0;
    decode_enable = 1'b0;
    rf_read_en    = 1'b0;
    alu_en        = 1'b0;
    alu_op        = ALU_ADD;
    alu_src_imm   = 1'b0;
    rf_write_en   = 1'b0;
    rf_dst_rd     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_FETCH;
          pc_d       = '0;
          err_code_d = ERR_NONE;
          tmo_d      = '0;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        // An ack on the last allowed cycle still wins over the timeout.
        if (imem_ack) begin
          instr_d = imem_data;
          tmo_d   = '0;
          state_d = ST_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d      = '0;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DECODE: begin
        decode_enable = 1'b1;
        state_d       = ST_EXEC;
      end
      ST_EXEC: begin
        if (fc_legal) begin
          rf_read_en  = 1'b1;
          alu_en      = 1'b1;
          alu_op      = fc_alu_op;
          alu_src_imm = fc_src_imm;
          rf_dst_rd   = fc_dst_rd;
          state_d     = ST_WB;
        end else begin
          err_code_d = ERR_ILLEGAL;
          state_d    = ST_ERROR;
        end
      end
      ST_WB: begin
        rf_write_en = 1'b1;
        alu_op      = fc_alu_op;
        alu_src_imm = fc_src_imm;
        rf_dst_rd   = fc_dst_rd;
        pc_d        = pc_q + PC_W'(1);
        state_d     = (pc_q == LAST_PC) ? ST_DONE : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instruct  = instr_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                     (state_q == ST_EXEC)  || (state_q == ST_WB);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized scoreboard bench: a program-level model predicts each strobe event and
// its cycle; a negedge monitor pops and compares. A second instance checks pc wrap.
module tb_instr_sequencer;

  localparam int PC_W   = 8;
  localparam int PLEN_A = 2;
  localparam int PLEN_B = 256;
  localparam int TMO    = 15;

  localparam int K_FETCH = 0, K_DEC = 1, K_EXEC = 2, K_WB = 3, K_DONE = 4, K_ERR = 5;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A (PROG_LEN=2, scoreboarded) ----------------
  logic            start_a, imem_req_a, imem_ack_a, decode_enable_a, rf_read_en_a, alu_en_a;
  logic            alu_src_imm_a, rf_write_en_a, rf_dst_rd_a, busy_a, done_a, err_a;
  logic [PC_W-1:0] imem_addr_a, pc_a;
  logic [31:0]     imem_data_a, instruct_a;
  logic [5:0]      opcode_a = 6'd0, func_a = 6'd0;
  logic [1:0]      alu_op_a, err_code_a;
  logic [63:0]     outs_a;

  instr_sequencer #(.PC_W(PC_W), .PROG_LEN(PLEN_A), .ACK_TMO(TMO)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .imem_req(imem_req_a), .imem_addr(imem_addr_a), .imem_ack(imem_ack_a), .imem_data(imem_data_a),
    .instruct(instruct_a), .decode_enable(decode_enable_a), .opcode(opcode_a), .func(func_a),
    .rf_read_en(rf_read_en_a), .alu_en(alu_en_a), .alu_op(alu_op_a), .alu_src_imm(alu_src_imm_a),
    .rf_write_en(rf_write_en_a), .rf_dst_rd(rf_dst_rd_a), .busy(busy_a), .done(done_a),
    .err(err_a), .err_code(err_code_a), .pc(pc_a)
  );

  assign outs_a = {2'b00, imem_req_a, imem_addr_a, instruct_a, decode_enable_a, rf_read_en_a,
                   alu_en_a, alu_op_a, alu_src_imm_a, rf_write_en_a, rf_dst_rd_a, busy_a,
                   done_a, err_a, err_code_a, pc_a};

  // ---------------- instance B (PROG_LEN=256, pc wrap) ----------------
  logic            start_b, imem_req_b, decode_enable_b, rf_read_en_b, alu_en_b;
  logic            alu_src_imm_b, rf_write_en_b, rf_dst_rd_b, busy_b, done_b, err_b;
  logic [PC_W-1:0] imem_addr_b, pc_b;
  logic [31:0]     instruct_b;
  logic [5:0]      opcode_b = 6'd0, func_b = 6'd0;
  logic [1:0]      alu_op_b, err_code_b;

  instr_sequencer #(.PC_W(PC_W), .PROG_LEN(PLEN_B), .ACK_TMO(TMO)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(1'b1), .imem_data(32'h00221821),
    .instruct(instruct_b), .decode_enable(decode_enable_b), .opcode(opcode_b), .func(func_b),
    .rf_read_en(rf_read_en_b), .alu_en(alu_en_b), .alu_op(alu_op_b), .alu_src_imm(alu_src_imm_b),
    .rf_write_en(rf_write_en_b), .rf_dst_rd(rf_dst_rd_b), .busy(busy_b), .done(done_b),
    .err(err_b), .err_code(err_code_b), .pc(pc_b)
  );

  // Decoder models: capture fields on the negedge inside the DECODE cycle.
  always @(negedge clk) begin
    if (decode_enable_a) begin opcode_a = instruct_a[31:26]; func_a = instruct_a[5:0]; end
    if (decode_enable_b) begin opcode_b = instruct_b[31:26]; func_b = instruct_b[5:0]; end
  end

  // Instruction memory for A: ack after dly_a[pc] wait cycles; random noise outside FETCH.
  logic [31:0] prog_a [0:255];
  int          dly_a  [0:255];
  int          wait_a = 0;
  logic        req_seen_a = 1'b0;

  initial begin imem_ack_a = 1'b0; imem_data_a = 32'h0; end

  always @(posedge clk) begin
    #1;
    if (imem_req_a) begin
      if (req_seen_a) wait_a++;
      else wait_a = 0;
      imem_ack_a  = (wait_a == dly_a[imem_addr_a]);
      imem_data_a = imem_ack_a ? prog_a[imem_addr_a] : $urandom;
    end else begin
      wait_a      = 0;
      imem_ack_a  = 1'($urandom_range(0, 1));
      imem_data_a = $urandom;
    end
    req_seen_a = imem_req_a;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input int kind, input logic [31:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind %0d val %h at cycle %0d, expected no event", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val !== val) begin
        errors++;
        $display("FAIL sb_event: got kind %0d cyc %0d val %h, expected kind %0d cyc %0d val %h",
                 kind, cyc, val, e.kind, e.cyc, e.val);
      end
    end
  endtask

  logic done_prev = 1'b0, err_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req_a && imem_ack_a) check_ev(K_FETCH, 32'(imem_addr_a));
      if (decode_enable_a)           check_ev(K_DEC, instruct_a);
      if (alu_en_a)      check_ev(K_EXEC, 32'({rf_read_en_a, alu_op_a, alu_src_imm_a, rf_dst_rd_a}));
      if (rf_write_en_a) check_ev(K_WB,   32'({rf_read_en_a, alu_op_a, alu_src_imm_a, rf_dst_rd_a}));
      if (done_a && !done_prev) check_ev(K_DONE, 32'(pc_a));
      if (err_a && !err_prev)   check_ev(K_ERR, 32'({err_code_a, pc_a}));
      if (imem_req_a || decode_enable_a || alu_en_a || rf_write_en_a)
        chk("strobe_onehot", 64'(int'(imem_req_a) + int'(decode_enable_a) + int'(alu_en_a) +
                                 int'(rf_write_en_a)), 64'd1);
    end
    done_prev = done_a;
    err_prev  = err_a;
  end

  // ---------------- reference model ----------------
  task automatic ref_ctrl(input logic [31:0] ins, output bit lg, output logic [3:0] c);
    lg = 1'b1;
    c  = 4'b0000;
    if (ins[31:26] == 6'd9) c = 4'b0010;
    else if (ins[31:26] == 6'd0) begin
      case (ins[5:0])
        6'h21:   c = 4'b0001;
        6'h23:   c = 4'b0101;
        6'h24:   c = 4'b1001;
        6'h25:   c = 4'b1101;
        default: lg = 1'b0;
      endcase
    end else lg = 1'b0;
  endtask

  task automatic push(input int kind, input int t, input logic [31:0] val);
    ev_t e;
    e.kind = kind; e.cyc = t; e.val = val;
    exp_q.push_back(e);
  endtask

  // s is the cycle of the first FETCH.
  task automatic push_model(input int s, input int n);
    int t, acc;
    bit lg;
    logic [3:0] c;
    t = s;
    for (int i = 0; i < n; i++) begin
      if (dly_a[i] >= TMO) begin
        push(K_ERR, t + TMO, 32'({2'b10, 8'(i)}));
        return;
      end
      acc = t + dly_a[i];
      push(K_FETCH, acc, 32'(i));
      push(K_DEC, acc + 1, prog_a[i]);
      ref_ctrl(prog_a[i], lg, c);
      if (!lg) begin
        push(K_ERR, acc + 3, 32'({2'b01, 8'(i)}));
        return;
      end
      push(K_EXEC, acc + 2, 32'({1'b1, c}));
      push(K_WB,   acc + 3, 32'({1'b0, c}));
      t = acc + 4;
    end
    push(K_DONE, t, 32'(n % 256));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 11);
    if (r < 8) begin
      w[31:26] = (r < 5) ? 6'd0 : 6'd9;
      if (r < 5) begin
        w[10:6] = 5'd0;
        case (r)
          0:       w[5:0] = 6'h21;
          1:       w[5:0] = 6'h23;
          2:       w[5:0] = 6'h24;
          default: w[5:0] = 6'h25;
        endcase
      end
    end else if (r < 10) begin
      w[31:26] = 6'd0;
      if (w[5:0] inside {6'h21, 6'h23, 6'h24, 6'h25}) w[5:0] = 6'h2A;
    end else begin
      if (w[31:26] == 6'd0 || w[31:26] == 6'd9) w[31:26] = 6'd10;
    end
    return w;
  endfunction

  function automatic int rand_dly();
    int r;
    r = $urandom_range(0, 15);
    if (r < 12) return r % 4;
    if (r < 14) return TMO - 1;
    return 99;
  endfunction

  task automatic run_a(input int n);
    int  s;
    bit  fin;
    @(negedge clk);
    start_a = 1'b1;
    s = cyc + 1;
    push_model(s, n);
    @(negedge clk);
    start_a = 1'b0;
    chk("start_flags", 64'({busy_a, done_a, err_a, err_code_a, pc_a}), 64'({1'b1, 12'd0}));
    fin = 1'b0;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(negedge clk);
      if (done_a || err_a) fin = 1'b1;
      else start_a = busy_a && ($urandom_range(0, 3) == 0);
    end
    start_a = 1'b0;
    if (!fin) chk("run_timeout", 64'(fin), 64'd1);
    repeat (2) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int  s, ds;
    bit  fin;
    logic [PC_W-1:0] last_wb_pc;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 256; i++) begin prog_a[i] = 32'h00221821; dly_a[i] = 0; end
    @(negedge clk); @(negedge clk);
    chk("reset_outputs", outs_a, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", outs_a, 64'd0);

    // addu then addiu, same-cycle ack: done 8 cycles after first FETCH.
    prog_a[0] = 32'h00221821; prog_a[1] = 32'h24010005;
    run_a(PLEN_A);
    // First fetch waits 3 extra cycles.
    dly_a[0] = 3;
    run_a(PLEN_A);
    // Ack on the final allowed FETCH cycle.
    dly_a[0] = TMO - 1; dly_a[1] = 1;
    run_a(PLEN_A);
    // Illegal func 0x2A.
    dly_a[0] = 0; dly_a[1] = 0; prog_a[0] = 32'h0022182A;
    run_a(PLEN_A);
    chk("illegal_code", 64'({err_a, err_code_a, pc_a}), 64'({1'b1, 2'b01, 8'd0}));
    // No ack at all, then a clean restart.
    prog_a[0] = 32'h00221821; dly_a[0] = 99;
    run_a(PLEN_A);
    chk("timeout_code", 64'({err_a, err_code_a}), 64'({1'b1, 2'b10}));
    dly_a[0] = 0;
    run_a(PLEN_A);

    // Async reset in the middle of EXEC.
    @(negedge clk);
    start_a = 1'b1;
    s = cyc + 1;
    push_model(s, PLEN_A);
    @(negedge clk);
    start_a = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < 20 && !fin; k++) begin
      if (alu_en_a) fin = 1'b1;
      else @(negedge clk);
    end
    chk("reach_exec", 64'(fin), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_async_outputs", outs_a, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", outs_a, 64'd0);

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < PLEN_A; i++) begin prog_a[i] = rand_instr(); dly_a[i] = rand_dly(); end
      run_a(PLEN_A);
    end

    // 256-instruction program: pc wraps to 0 as done rises; a mid-run start is ignored.
    @(negedge clk);
    start_b = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start_b = 1'b0;
    fin = 1'b0; ds = 0; last_wb_pc = '0;
    for (int k = 0; k < 1200 && !fin; k++) begin
      @(negedge clk);
      if (rf_write_en_b) last_wb_pc = pc_b;
      if (done_b) begin fin = 1'b1; ds = cyc; end
      start_b = (k == 100);
    end
    start_b = 1'b0;
    chk("wrap_done_seen", 64'(fin), 64'd1);
    chk("wrap_done_cycle", 64'(ds), 64'(s + 4 * PLEN_B));
    chk("wrap_pc_at_done", 64'(pc_b), 64'd0);
    chk("wrap_last_wb_pc", 64'(last_wb_pc), 64'd255);
    chk("wrap_no_err", 64'({err_b, err_code_b}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
